// File: rtl/softmax_pkg.sv
// Shared types, limits and the saturating subtract used by the softmax front end.
package softmax_pkg;

    localparam int LOGIT_W  = 17;   // Q5.11 signed logit
    localparam int VEC_SIZE = 5;    // elements per softmax vector

    typedef logic signed [LOGIT_W-1:0] logit_t;
    typedef logit_t logit_vec_t [1:VEC_SIZE];

    localparam logit_t LOGIT_MIN = {1'b1, {(LOGIT_W-1){1'b0}}};
    localparam logit_t LOGIT_MAX = {1'b0, {(LOGIT_W-1){1'b1}}};

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } loader_state_t;

    // a - b evaluated one bit wider, then clamped back into the logit range.
    // Overflow shows up as the two top bits of the wide result disagreeing.
    function automatic logit_t sat_sub(input logit_t a, input logit_t b);
        logic signed [LOGIT_W:0] diff;
        diff = {a[LOGIT_W-1], a} - {b[LOGIT_W-1], b};
        if (diff[LOGIT_W] != diff[LOGIT_W-1]) begin
            return diff[LOGIT_W] ? LOGIT_MIN : LOGIT_MAX;
        end
        return diff[LOGIT_W-1:0];
    endfunction

endpackage

// File: rtl/softmax_input_loader_max.sv
// Running signed maximum of the elements accepted into the current vector.
// max_next_o already includes the element being accepted this cycle.
module vec_max_tracker
    import softmax_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr_i,
    input  logic   upd_i,
    input  logit_t din_i,
    output logit_t max_next_o
);

    logit_t max_q;

    assign max_next_o = (upd_i && (din_i > max_q)) ? din_i : max_q;

    // Clear wins over update: a completing vector hands max_next_o to the
    // output stage and the tracker restarts for the next vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= LOGIT_MIN;
        end else if (clr_i) begin
            max_q <= LOGIT_MIN;
        end else if (upd_i) begin
            max_q <= max_next_o;
        end
    end

endmodule

// File: rtl/softmax_input_loader.sv
// Collects scalar logits into a vector, subtracts the vector max and presents
// the result in parallel. One vector can be held complete (pending) in the
// bank while the previous one still waits in the output register.
module softmax_input_loader
    import softmax_pkg::*;
#(
    parameter int SIZE    = VEC_SIZE,
    parameter int W       = LOGIT_W,
    parameter int PAD_VAL = -65536
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x [1:SIZE],
    output logic         err_last
);

    localparam int     CNT_W = $clog2(SIZE);
    localparam logit_t PAD   = logit_t'(PAD_VAL);

    loader_state_t state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logit_t bank_q  [1:SIZE];
    logit_t bank_d  [1:SIZE];
    logit_t out_x_q [1:SIZE];
    logit_t out_x_d [1:SIZE];
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   err_last_q, err_last_d;
    logit_t max_next;

    logic accept, at_end, complete, slot_free, load;

    assign accept    = in_valid && in_ready_q;
    assign at_end    = (count_q == CNT_W'(SIZE - 1));
    assign complete  = accept && (in_last || at_end);
    assign slot_free = !out_valid_q || out_ready;
    assign load      = slot_free &&
                       ((state_q == ST_COLLECT && complete) || (state_q == ST_PENDING));

    vec_max_tracker u_max (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (load),
        .upd_i      (accept),
        .din_i      (logit_t'(in_data)),
        .max_next_o (max_next)
    );

    // Bank write of the accepted element (plus padding on an early last) and
    // the normalized output image built from that same updated bank.
    always_comb begin
        for (int i = 1; i <= SIZE; i++) begin
            bank_d[i] = bank_q[i];
            if (accept) begin
                if (i == int'(count_q) + 1) begin
                    bank_d[i] = logit_t'(in_data);
                end else if (in_last && i > int'(count_q) + 1) begin
                    bank_d[i] = PAD;
                end
            end
            out_x_d[i] = load ? sat_sub(bank_d[i], max_next) : out_x_q[i];
        end
    end

    // Collect/pending control; in_ready is registered from the next state so
    // it never depends combinationally on out_ready.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q && !out_ready;
        err_last_d  = complete && at_end && !in_last;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (!complete) begin
                        count_d = count_q + CNT_W'(1);
                    end else if (slot_free) begin
                        count_d = '0;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (slot_free) begin
                    state_d = ST_COLLECT;
                    count_d = '0;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
        if (load) begin
            out_valid_d = 1'b1;
        end
        in_ready_d = (state_d == ST_COLLECT);
    end

    // State, bank and output registers; reset discards any partial vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            err_last_q  <= 1'b0;
            for (int i = 1; i <= SIZE; i++) begin
                bank_q[i]  <= '0;
                out_x_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            err_last_q  <= err_last_d;
            for (int i = 1; i <= SIZE; i++) begin
                bank_q[i]  <= bank_d[i];
                out_x_q[i] <= out_x_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err_last  = err_last_q;

    for (genvar gi = 1; gi <= SIZE; gi++) begin : g_out
        assign out_x[gi] = out_x_q[gi];
    end

endmodule

// File: tb/tb_softmax_input_loader.sv
// Directed bench for softmax_input_loader: hand-computed vectors, one line per
// transaction, single summary line at the end.
module tb_softmax_input_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_x [1:5];
    logic        err_last;

    int n_checks = 0;
    int n_errors = 0;

    softmax_input_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .err_last  (err_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [16:0] v);
        return int'($signed(v));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one element and hold it until it is accepted (bounded wait).
    task automatic send(input int d, input logic last);
        int budget;
        in_valid = 1'b1;
        in_data  = 17'(d);
        in_last  = last;
        budget   = 50;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!in_ready) begin
            chk("send_ready_timeout", 0, 1);
        end else begin
            tick();
            $display("send data=%0d last=%0b", d, last);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_vec(input string tag, input int e1, input int e2,
                           input int e3, input int e4, input int e5);
        int e [1:5];
        e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4; e[5] = e5;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("%s_x%0d", tag, i), sx(out_x[i]), e[i]);
        end
        $display("vector %s: %0d %0d %0d %0d %0d", tag,
                 sx(out_x[1]), sx(out_x[2]), sx(out_x[3]), sx(out_x[4]), sx(out_x[5]));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err_last", int'(err_last), 0);
        chk_vec("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk("rel_in_ready", int'(in_ready), 1);

        // Basic vector
        send(2048, 0); send(4096, 0); send(0, 0); send(-2048, 0); send(1024, 1);
        chk("basic_valid", int'(out_valid), 1);
        chk("basic_err", int'(err_last), 0);
        chk_vec("basic", -2048, 0, -4096, -6144, -3072);
        tick();
        chk("basic_drop", int'(out_valid), 0);

        // Saturation
        send(-65536, 0); send(65535, 0); send(0, 0); send(0, 0); send(0, 1);
        chk("sat_valid", int'(out_valid), 1);
        chk_vec("sat", -65536, 0, -65535, -65535, -65535);
        tick();

        // Early last with padding
        send(100, 0); send(300, 0); send(200, 1);
        chk("early_valid", int'(out_valid), 1);
        chk("early_err", int'(err_last), 0);
        chk_vec("early", -200, 0, -100, -65536, -65536);
        tick();
        chk("early_err2", int'(err_last), 0);

        // Missing last: vector still output, err_last pulses once
        send(10, 0); send(20, 0); send(30, 0); send(40, 0); send(50, 0);
        chk("miss_valid", int'(out_valid), 1);
        chk("miss_err_pulse", int'(err_last), 1);
        chk_vec("miss", -40, -30, -20, -10, 0);
        tick();
        chk("miss_err_clear", int'(err_last), 0);

        // Back-pressure: two vectors while the consumer stalls
        out_ready = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(5, 1);
        chk("bp_v1_valid", int'(out_valid), 1);
        chk_vec("bp_v1", -4, -3, -2, -1, 0);
        send(500, 0); send(-500, 0); send(0, 0); send(250, 0); send(-250, 1);
        chk("bp_pending_ready", int'(in_ready), 0);
        chk_vec("bp_hold_a", -4, -3, -2, -1, 0);
        tick(); tick(); tick();
        chk("bp_still_ready", int'(in_ready), 0);
        chk("bp_still_valid", int'(out_valid), 1);
        chk_vec("bp_hold_b", -4, -3, -2, -1, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_v2_valid", int'(out_valid), 1);
        chk("bp_ready_back", int'(in_ready), 1);
        chk_vec("bp_v2", 0, -1000, -500, -250, -750);
        tick();
        chk_vec("bp_v2_hold", 0, -1000, -500, -250, -750);
        out_ready = 1'b1;
        tick();
        chk("bp_drop", int'(out_valid), 0);

        // Async reset mid-vector with a held output vector
        out_ready = 1'b0;
        send(100, 0); send(200, 0); send(300, 0); send(400, 0); send(500, 1);
        chk_vec("pre_rst", -400, -300, -200, -100, 0);
        send(7000, 0); send(8000, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        chk_vec("arst", 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("arst_rel_ready", int'(in_ready), 1);
        send(0, 0); send(-100, 0); send(-200, 0); send(-300, 0); send(-400, 1);
        chk("fresh_valid", int'(out_valid), 1);
        chk("fresh_err", int'(err_last), 0);
        chk_vec("fresh", 0, -100, -200, -300, -400);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
